// File: rtl/punc_debug_dumper_if.sv
// Dump word stream from the PUnC debug dumper to its sink (UART, trace buffer).
// A word moves when dump_valid and dump_ready are both high on a clock edge.
interface punc_debug_dumper_if;
    logic        dump_valid;
    logic        dump_ready;
    logic [15:0] dump_data;
    logic [1:0]  dump_tag;
    logic [15:0] dump_addr;
    logic        dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_tag,
        output dump_addr,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_tag,
        input  dump_addr,
        input  dump_last,
        output dump_ready
    );
endinterface

// File: rtl/punc_debug_dumper.sv
// Host-side reader for the PUnC debug port. One start pulse snapshots PC,
// R0..R7 and a memory window [mem_base, mem_base+mem_count) and streams the
// words, one at a time, on the dump interface.
module punc_debug_dumper #(
    parameter int unsigned RD_LATENCY = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [15:0]                mem_base,
    input  logic [15:0]                mem_count,
    output logic [15:0]                mem_debug_addr,
    output logic [2:0]                 rf_debug_addr,
    input  logic [15:0]                mem_debug_data,
    input  logic [15:0]                rf_debug_data,
    input  logic [15:0]                pc_debug_data,
    punc_debug_dumper_if.master        dump,
    output logic                       busy,
    output logic                       done
);

    localparam logic [1:0] LAT      = 2'(RD_LATENCY);
    localparam logic [3:0] ELEM_PC  = 4'd0;
    localparam logic [3:0] ELEM_R7  = 4'd8;
    localparam logic [3:0] ELEM_MEM = 4'd9;

    localparam logic [1:0] TAG_PC  = 2'b00;
    localparam logic [1:0] TAG_RF  = 2'b01;
    localparam logic [1:0] TAG_MEM = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_HOLD,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    // Element index: 0 = PC, 1..8 = R0..R7, 9 = memory window (walked by mem_idx)
    logic [3:0]  reg_idx;
    logic [15:0] mem_idx;
    logic [1:0]  wait_cnt;
    logic [15:0] base_q;
    logic [15:0] count_q;

    logic [15:0] data_q;
    logic [1:0]  tag_q;
    logic [15:0] addr_q;
    logic        last_q;
    logic        valid_c;

    logic        setup_done;
    logic        transfer;
    logic        elem_last;

    assign setup_done = (state == S_SETUP) && (wait_cnt == LAT);
    assign transfer   = (state == S_HOLD) && dump.dump_ready;
    assign elem_last  = (reg_idx == ELEM_MEM) ? (mem_idx == count_q - 16'd1)
                                              : ((reg_idx == ELEM_R7) && (count_q == '0));

    assign dump.dump_valid = valid_c;
    assign dump.dump_data  = data_q;
    assign dump.dump_tag   = tag_q;
    assign dump.dump_addr  = addr_q;
    assign dump.dump_last  = last_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs
    always_comb begin
        state_next = state;
        valid_c    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                busy = 1'b1;
                if (wait_cnt == LAT) begin
                    state_next = S_HOLD;
                end
            end
            S_HOLD: begin
                busy    = 1'b1;
                valid_c = 1'b1;
                if (dump.dump_ready) begin
                    state_next = last_q ? S_DONE : S_SETUP;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Element sequencing, debug address drive and word capture
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q         <= '0;
            count_q        <= '0;
            reg_idx        <= '0;
            mem_idx        <= '0;
            wait_cnt       <= '0;
            mem_debug_addr <= '0;
            rf_debug_addr  <= '0;
            data_q         <= '0;
            tag_q          <= '0;
            addr_q         <= '0;
            last_q         <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q   <= mem_base;
                        count_q  <= mem_count;
                        reg_idx  <= ELEM_PC;
                        mem_idx  <= '0;
                        wait_cnt <= '0;
                    end
                end
                S_SETUP: begin
                    if (setup_done) begin
                        wait_cnt <= '0;
                        last_q   <= elem_last;
                        if (reg_idx == ELEM_PC) begin
                            data_q <= pc_debug_data;
                            tag_q  <= TAG_PC;
                            addr_q <= '0;
                        end else if (reg_idx == ELEM_MEM) begin
                            data_q <= mem_debug_data;
                            tag_q  <= TAG_MEM;
                            addr_q <= mem_debug_addr;
                        end else begin
                            data_q <= rf_debug_data;
                            tag_q  <= TAG_RF;
                            addr_q <= {13'd0, rf_debug_addr};
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 2'd1;
                    end
                end
                S_HOLD: begin
                    // Addresses for the next element are launched on the
                    // transfer edge so they are fresh on the first SETUP cycle.
                    if (transfer && !last_q) begin
                        if (reg_idx < ELEM_R7) begin
                            reg_idx       <= reg_idx + 4'd1;
                            rf_debug_addr <= reg_idx[2:0];
                        end else if (reg_idx == ELEM_R7) begin
                            reg_idx        <= ELEM_MEM;
                            mem_debug_addr <= base_q;
                        end else begin
                            mem_idx        <= mem_idx + 16'd1;
                            mem_debug_addr <= base_q + mem_idx + 16'd1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Directed bench for punc_debug_dumper: one instance at RD_LATENCY=0 and one
// at RD_LATENCY=2, each attached to a small PUnC debug-port model.
module tb_punc_debug_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start0, start1;
    logic [15:0] base0, count0, base1, count1;
    logic [15:0] maddr0, maddr1;
    logic [2:0]  raddr0, raddr1;
    logic [15:0] mdat0, rdat0, mdat1, rdat1, m1a, r1a;
    logic        busy0, done0, busy1, done1;

    localparam logic [15:0] PC0 = 16'h0123;
    localparam logic [15:0] PC1 = 16'h0456;

    int checks   = 0;
    int failures = 0;

    punc_debug_dumper_if if0();
    punc_debug_dumper_if if1();

    punc_debug_dumper #(.RD_LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .mem_base(base0), .mem_count(count0),
        .mem_debug_addr(maddr0), .rf_debug_addr(raddr0),
        .mem_debug_data(mdat0), .rf_debug_data(rdat0), .pc_debug_data(PC0),
        .dump(if0.master), .busy(busy0), .done(done0)
    );

    punc_debug_dumper #(.RD_LATENCY(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .mem_base(base1), .mem_count(count1),
        .mem_debug_addr(maddr1), .rf_debug_addr(raddr1),
        .mem_debug_data(mdat1), .rf_debug_data(rdat1), .pc_debug_data(PC1),
        .dump(if1.master), .busy(busy1), .done(done1)
    );

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        case (a)
            16'h3000: return 16'h1111;
            16'h3001: return 16'h2222;
            16'h3002: return 16'h3333;
            default:  return a ^ 16'hA5C3;
        endcase
    endfunction

    function automatic logic [15:0] rf_fn(input logic [2:0] i);
        return 16'hB000 + 16'(i) * 16'h0111;
    endfunction

    // PUnC model, zero latency
    assign mdat0 = mem_fn(maddr0);
    assign rdat0 = rf_fn(raddr0);

    // PUnC model, two-cycle read latency
    always @(posedge clk) begin
        m1a   <= mem_fn(maddr1);
        mdat1 <= m1a;
        r1a   <= rf_fn(raddr1);
        rdat1 <= r1a;
    end

    task automatic sample(input int inst, output logic v, output logic [15:0] d,
                          output logic [1:0] t, output logic [15:0] a, output logic l,
                          output logic b, output logic dn, output logic [15:0] ma,
                          output logic [2:0] ra);
        if (inst == 0) begin
            v = if0.dump_valid; d = if0.dump_data; t = if0.dump_tag; a = if0.dump_addr;
            l = if0.dump_last; b = busy0; dn = done0; ma = maddr0; ra = raddr0;
        end else begin
            v = if1.dump_valid; d = if1.dump_data; t = if1.dump_tag; a = if1.dump_addr;
            l = if1.dump_last; b = busy1; dn = done1; ma = maddr1; ra = raddr1;
        end
    endtask

    task automatic set_ready(input int inst, input logic r);
        if (inst == 0) if0.dump_ready = r;
        else           if1.dump_ready = r;
    endtask

    task automatic drive_start(input int inst, input logic s, input logic [15:0] b,
                               input logic [15:0] c);
        if (inst == 0) begin start0 = s; base0 = b; count0 = c; end
        else           begin start1 = s; base1 = b; count1 = c; end
    endtask

    task automatic exp_word(input int k, input logic [15:0] base, input logic [15:0] count,
                            input logic [15:0] pc, output logic [15:0] d,
                            output logic [1:0] t, output logic [15:0] a, output logic l);
        if (k == 0) begin
            d = pc; t = 2'b00; a = 16'h0000;
        end else if (k <= 8) begin
            t = 2'b01; a = 16'(k - 1); d = rf_fn(3'(k - 1));
        end else begin
            t = 2'b10; a = base + 16'(k - 9); d = mem_fn(a);
        end
        l = (k == 8 + int'(count));
    endtask

    // One complete dump on instance inst, checking every word, its timing,
    // hold stability, busy and the done pulse
    task automatic run_dump(input string name, input int inst, input logic [15:0] base,
                            input logic [15:0] count, input bit rand_ready, input bit inject);
        int lat = (inst == 0) ? 0 : 2;
        int cyc = 0;
        int words = 0;
        int next_valid = lat + 2;
        int final_t = -1;
        bit finished = 0;
        bit prev_hold = 0;
        logic [15:0] pd, pa, ed, ea;
        logic [1:0]  pt, et;
        logic        pl, el;
        logic v, l, b, dn, r;
        logic [15:0] d, a, ma;
        logic [1:0]  t;
        logic [2:0]  ra;
        logic [15:0] pc = (inst == 0) ? PC0 : PC1;
        pd = '0; pa = '0; pt = '0; pl = 1'b0;

        @(negedge clk);
        drive_start(inst, 1'b1, base, count);
        while (!finished && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) drive_start(inst, 1'b0, 16'hDEAD, 16'h0040);
            if (inject && cyc == 6) drive_start(inst, 1'b1, 16'h1234, 16'h0007);
            if (inject && cyc == 7) drive_start(inst, 1'b0, 16'h0000, 16'h0000);
            sample(inst, v, d, t, a, l, b, dn, ma, ra);
            if (final_t >= 0) begin
                set_ready(inst, 1'b0);
                checks++;
                if (dn !== 1'b1 || b !== 1'b0 || v !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_pulse: got done=%b busy=%b valid=%b, want 1 0 0",
                             name, dn, b, v);
                end
                @(negedge clk);
                sample(inst, v, d, t, a, l, b, dn, ma, ra);
                checks++;
                if (dn !== 1'b0 || b !== 1'b0 || v !== 1'b0) begin
                    failures++;
                    $display("FAIL %s idle_after_done: got done=%b busy=%b valid=%b, want 0 0 0",
                             name, dn, b, v);
                end
                finished = 1;
            end else begin
                checks++;
                if (b !== 1'b1) begin
                    failures++;
                    $display("FAIL %s busy: cycle %0d got %b want 1", name, cyc, b);
                end
                if (prev_hold) begin
                    checks++;
                    if (v !== 1'b1 || d !== pd || t !== pt || a !== pa || l !== pl) begin
                        failures++;
                        $display("FAIL %s hold_stable: cycle %0d got v=%b %h/%b/%h/%b want 1 %h/%b/%h/%b",
                                 name, cyc, v, d, t, a, l, pd, pt, pa, pl);
                    end
                end else if (v === 1'b1) begin
                    checks++;
                    if (cyc != next_valid) begin
                        failures++;
                        $display("FAIL %s valid_timing: word %0d valid at cycle %0d want %0d",
                                 name, words, cyc, next_valid);
                    end
                    exp_word(words, base, count, pc, ed, et, ea, el);
                    checks++;
                    if (d !== ed || t !== et || a !== ea || l !== el) begin
                        failures++;
                        $display("FAIL %s word%0d: got data=%h tag=%b addr=%h last=%b want %h %b %h %b",
                                 name, words, d, t, a, l, ed, et, ea, el);
                    end
                end
                r = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                set_ready(inst, r);
                if (v === 1'b1 && r) begin
                    words++;
                    if (l === 1'b1) final_t = cyc;
                    next_valid = cyc + lat + 2;
                    prev_hold = 0;
                end else begin
                    prev_hold = (v === 1'b1);
                    pd = d; pt = t; pa = a; pl = l;
                end
            end
        end
        set_ready(inst, 1'b0);
        checks++;
        if (!finished || words != 9 + int'(count)) begin
            failures++;
            $display("FAIL %s word_count: got %0d words (finished=%0d) want %0d",
                     name, words, finished, 9 + int'(count));
        end
    endtask

    task automatic test_reset();
        logic v, l, b, dn;
        logic [15:0] d, a, ma;
        logic [1:0]  t;
        logic [2:0]  ra;
        bit seen;
        for (int ph = 0; ph < 2; ph++) begin
            if (ph == 1) begin
                // Park instance 0 in HOLD on a memory word, then reset it
                @(negedge clk);
                set_ready(0, 1'b1);
                drive_start(0, 1'b1, 16'h3000, 16'h0002);
                seen = 0;
                for (int c = 0; c < 200 && !seen; c++) begin
                    @(negedge clk);
                    drive_start(0, 1'b0, 16'h0000, 16'h0000);
                    if (if0.dump_valid === 1'b1 && if0.dump_tag === 2'b10) begin
                        set_ready(0, 1'b0);
                        seen = 1;
                    end
                end
                checks++;
                if (!seen) begin
                    failures++;
                    $display("FAIL reset_reach_hold: no memory word within 200 cycles");
                end
                @(negedge clk);
            end
            rst = 1'b1;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            for (int inst = 0; inst < 2; inst++) begin
                sample(inst, v, d, t, a, l, b, dn, ma, ra);
                checks++;
                if ({v, d, t, a, l, b, dn, ma, ra} !== '0) begin
                    failures++;
                    $display("FAIL reset_outputs ph%0d inst%0d: v=%b d=%h t=%b a=%h l=%b busy=%b done=%b ma=%h ra=%h want all 0",
                             ph, inst, v, d, t, a, l, b, dn, ma, ra);
                end
            end
        end
    endtask

    task automatic test_regs_only();
        run_dump("regs_only", 0, 16'h3000, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_mem_window();
        run_dump("mem_window", 0, 16'h3000, 16'h0003, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run_dump("wrap", 0, 16'hFFFE, 16'h0004, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_dump("backpressure_l2", 1, 16'h3000, 16'h0005, 1'b1, 1'b0);
        run_dump("backpressure_l0", 0, 16'h0100, 16'h0003, 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        run_dump("start_ignored_l2", 1, 16'h2000, 16'h0002, 1'b0, 1'b1);
        run_dump("start_ignored_l0", 0, 16'h4000, 16'h0001, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        run_dump("b2b_first", 1, 16'h0010, 16'h0001, 1'b0, 1'b0);
        run_dump("b2b_second", 1, 16'hFFFF, 16'h0002, 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        start0 = 1'b0; start1 = 1'b0;
        base0 = '0; count0 = '0; base1 = '0; count1 = '0;
        if0.dump_ready = 1'b0;
        if1.dump_ready = 1'b0;
        test_reset();
        test_regs_only();
        test_mem_window();
        test_wrap();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
